gon_ybus_ctrl: RTL and testbench

- Global-network Y-bus controller. Sits directly upstream of the per-row GON X-buses.
- Accepts tagged packets {row_tag, col_tag, data} from the global buffer over a valid/ready handshake and buffers them in a small FIFO.
- Multicasts each packet to every X-bus row whose row ID matches row_tag, driving the shared col_tag and data lines to those rows.
- Drops, and counts, packets that match no row.

---
 rtl/gon_ybus_ctrl_if.sv | 37 +++
 rtl/gon_ybus_ctrl.sv | 143 ++++++++++++++
 tb/tb_gon_ybus_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gon_ybus_ctrl_if.sv
// rtl/gon_ybus_ctrl_if.sv - packet input stream and X-bus row fan-out signals of the Y-bus controller
//
// Purpose: bundles the upstream packet handshake and the broadcast lines to
//          the per-row X-buses.
// Signals:
//   in_valid / in_ready           upstream packet handshake
//   in_row_tag, in_col_tag, in_data  packet fields
//   row_ready                     per-row ready from each X-bus
//   row_enable                    per-row one-cycle transfer enable
//   col_tag_out, data_out         column tag and payload broadcast to all rows
// Modports: slave = controller side, master = driver/observer side.
interface gon_ybus_ctrl_if #(
   parameter int DATA_WIDTH    = 64,
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int NUM_OF_ROWS   = 12
) ();
   logic                     in_valid;
   logic                     in_ready;
   logic [ROW_TAG_WIDTH-1:0] in_row_tag;
   logic [COL_TAG_WIDTH-1:0] in_col_tag;
   logic [DATA_WIDTH-1:0]    in_data;
   logic [NUM_OF_ROWS-1:0]   row_ready;
   logic [NUM_OF_ROWS-1:0]   row_enable;
   logic [COL_TAG_WIDTH-1:0] col_tag_out;
   logic [DATA_WIDTH-1:0]    data_out;

   modport slave (
      input  in_valid, in_row_tag, in_col_tag, in_data, row_ready,
      output in_ready, row_enable, col_tag_out, data_out
   );

   modport master (
      output in_valid, in_row_tag, in_col_tag, in_data, row_ready,
      input  in_ready, row_enable, col_tag_out, data_out
   );
endinterface

// File: rtl/gon_ybus_ctrl.sv
// rtl/gon_ybus_ctrl.sv - global-network Y-bus controller multicasting tagged packets to X-bus rows
//
// Purpose: buffers tagged packets in a small FIFO, then multicasts the head
//          packet to every row whose row_id matches its row tag. A head that
//          matches no row is dropped and counted.
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-low reset
//   bus         gon_ybus_ctrl_if.slave: packet input and X-bus fan-out
//   row_id      configured ID per row, sampled when a head is loaded
//   drop_count  saturating count of packets that matched no row
module gon_ybus_ctrl #(
   parameter int DATA_WIDTH    = 64,
   parameter int ROW_TAG_WIDTH = 4,
   parameter int COL_TAG_WIDTH = 4,
   parameter int NUM_OF_ROWS   = 12,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                         clk,
   input  logic                                         reset,
   gon_ybus_ctrl_if.slave                               bus,
   input  logic [NUM_OF_ROWS-1:0][ROW_TAG_WIDTH-1:0]    row_id,
   output logic [7:0]                                   drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t state, next_state;

   logic [ROW_TAG_WIDTH-1:0] fifo_row  [FIFO_DEPTH];
   logic [COL_TAG_WIDTH-1:0] fifo_col  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count;

   logic [COL_TAG_WIDTH-1:0] head_col;
   logic [DATA_WIDTH-1:0]    head_data;
   logic [NUM_OF_ROWS-1:0]   head_mask;
   logic [NUM_OF_ROWS-1:0]   load_mask;

   logic full, not_empty, push, pop;
   logic release_head, do_drop, do_xfer;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign not_empty = (count != '0);
   // Ready depends on fullness only: a pop in the same cycle does not free a slot early.
   assign bus.in_ready = !full;
   assign push         = bus.in_valid && !full;

   // Outputs follow the head register and therefore keep their last value when empty.
   assign bus.col_tag_out = head_col;
   assign bus.data_out    = head_data;

   always_comb begin
      load_mask = '0;
      for (int i = 0; i < NUM_OF_ROWS; i++) begin
         load_mask[i] = (fifo_row[rd_ptr] == row_id[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state     = state;
      release_head   = 1'b0;
      do_drop        = 1'b0;
      do_xfer        = 1'b0;
      pop            = 1'b0;
      bus.row_enable = '0;
      case (state)
         EMPTY: begin
            pop = not_empty;
         end
         HOLD: begin
            if (head_mask == '0) begin
               do_drop      = 1'b1;
               release_head = 1'b1;
            end else if ((bus.row_ready & head_mask) == head_mask) begin
               // All targeted rows must be ready together; never a partial multicast.
               do_xfer        = 1'b1;
               release_head   = 1'b1;
               bus.row_enable = head_mask;
            end
            pop = release_head && not_empty;
         end
         default: ;
      endcase
      if (pop) begin
         next_state = HOLD;
      end else if (release_head) begin
         next_state = EMPTY;
      end
   end

   // Storage needs no reset: pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_row[wr_ptr]  <= bus.in_row_tag;
         fifo_col[wr_ptr]  <= bus.in_col_tag;
         fifo_data[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_col   <= '0;
         head_data  <= '0;
         head_mask  <= '0;
         drop_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + PTR_W'(1);
            head_col  <= fifo_col[rd_ptr];
            head_data <= fifo_data[rd_ptr];
            head_mask <= load_mask;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (do_drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_gon_ybus_ctrl.sv
// tb/tb_gon_ybus_ctrl.sv - self-checking bench for gon_ybus_ctrl
module tb_gon_ybus_ctrl;
   localparam int DW = 64;
   localparam int NR = 12;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   logic [NR-1:0][3:0] row_id;
   logic [7:0] drop_count;

   gon_ybus_ctrl_if #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4), .NUM_OF_ROWS(NR)) bus ();

   gon_ybus_ctrl #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(4), .COL_TAG_WIDTH(4),
                   .NUM_OF_ROWS(NR), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .row_id     (row_id),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  rt;
      logic [3:0]  ct;
      logic [63:0] d;
   } pkt_t;

   // Reference model: an ordered packet queue plus a head slot.
   pkt_t        fq[$];
   bit          hv;
   pkt_t        hp;
   logic [11:0] hm;
   int          m_drop;
   logic [3:0]  m_col;
   logic [63:0] m_data;

   typedef struct {
      logic        r;
      logic        v;
      logic [3:0]  rt;
      logic [3:0]  ct;
      logic [63:0] d;
      logic [11:0] rdy;
      logic        e_ready;
      logic [11:0] e_en;
      logic [3:0]  e_col;
      logic [63:0] e_data;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(logic r, logic v, logic [3:0] rt, logic [3:0] ct, logic [63:0] d,
                               logic [11:0] rdy, logic er, logic [11:0] een, logic [3:0] ec,
                               logic [63:0] ed, logic [7:0] edr);
      vec_t x;
      x.r = r; x.v = v; x.rt = rt; x.ct = ct; x.d = d; x.rdy = rdy;
      x.e_ready = er; x.e_en = een; x.e_col = ec; x.e_data = ed; x.e_drop = edr;
      return x;
   endfunction

   function automatic logic [11:0] mask_of(logic [3:0] rt);
      logic [11:0] m = '0;
      for (int i = 0; i < NR; i++) if (row_id[i] == rt) m[i] = 1'b1;
      return m;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic r, logic v, logic [3:0] rt, logic [3:0] ct, logic [63:0] d, logic [11:0] rdy);
      reset          = r;
      bus.in_valid   = v;
      bus.in_row_tag = rt;
      bus.in_col_tag = ct;
      bus.in_data    = d;
      bus.row_ready  = rdy;
   endtask

   function automatic logic [11:0] model_en();
      if (hv && hm != 0 && (bus.row_ready & hm) == hm) return hm;
      return '0;
   endfunction

   task automatic settle();
      #1;
      chk("in_ready",    bus.in_ready,    64'(fq.size() < DEPTH));
      chk("row_enable",  bus.row_enable,  64'(model_en()));
      chk("col_tag_out", bus.col_tag_out, 64'(m_col));
      chk("data_out",    bus.data_out,    m_data);
      chk("drop_count",  drop_count,      64'(m_drop));
   endtask

   task automatic model_update();
      bit rel, acc;
      pkt_t np;
      if (!reset) begin
         fq.delete();
         hv = 0; hm = '0; m_drop = 0; m_col = '0; m_data = '0;
      end else begin
         rel = hv && (hm == 0 || (bus.row_ready & hm) == hm);
         if (rel && hm == 0 && m_drop < 255) m_drop++;
         acc = bus.in_valid && (fq.size() < DEPTH);
         np.rt = bus.in_row_tag; np.ct = bus.in_col_tag; np.d = bus.in_data;
         if (!hv || rel) begin
            if (fq.size() > 0) begin
               hp = fq.pop_front();
               hm = mask_of(hp.rt);
               hv = 1;
               m_col = hp.ct; m_data = hp.d;
            end else begin
               hv = 0;
            end
         end
         if (acc) fq.push_back(np);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_identity();
      for (int i = 0; i < NR; i++) row_id[i] = 4'(i);
   endtask

   initial begin
      int acc;
      logic [11:0] rr;
      hv = 0; hm = '0; m_drop = 0; m_col = '0; m_data = '0;
      set_identity();

      tbl[0]  = mk(0, 1, 4'h3, 4'h5, 64'hA5A5, 12'hFFF, 1, 12'h000, 4'h0, 64'h0,    8'd0);
      tbl[1]  = mk(1, 1, 4'h3, 4'h5, 64'hA5A5, 12'hFFF, 1, 12'h000, 4'h0, 64'h0,    8'd0);
      tbl[2]  = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'hFFF, 1, 12'h000, 4'h0, 64'h0,    8'd0);
      tbl[3]  = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'hFFF, 1, 12'h008, 4'h5, 64'hA5A5, 8'd0);
      tbl[4]  = mk(1, 1, 4'hF, 4'h2, 64'h1234, 12'hFFF, 1, 12'h000, 4'h5, 64'hA5A5, 8'd0);
      tbl[5]  = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'hFFF, 1, 12'h000, 4'h5, 64'hA5A5, 8'd0);
      tbl[6]  = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'hFFF, 1, 12'h000, 4'h2, 64'h1234, 8'd0);
      tbl[7]  = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'hFFF, 1, 12'h000, 4'h2, 64'h1234, 8'd1);
      tbl[8]  = mk(1, 1, 4'hB, 4'h7, 64'hBEEF, 12'hFFF, 1, 12'h000, 4'h2, 64'h1234, 8'd1);
      tbl[9]  = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'h000, 1, 12'h000, 4'h2, 64'h1234, 8'd1);
      tbl[10] = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'h7FF, 1, 12'h000, 4'h7, 64'hBEEF, 8'd1);
      tbl[11] = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'h800, 1, 12'h800, 4'h7, 64'hBEEF, 8'd1);
      tbl[12] = mk(1, 0, 4'h0, 4'h0, 64'h0,    12'h000, 1, 12'h000, 4'h7, 64'hBEEF, 8'd1);

      // Reset held two cycles with in_valid high; first cycle outputs are still unknown.
      drive(0, 1, 4'h3, 4'h5, 64'h11, 12'hFFF);
      advance();
      drive(0, 1, 4'h3, 4'h5, 64'h11, 12'hFFF);
      settle();
      advance();

      // Table: unicast, drop 0->1, held-output behaviour, single-row stall.
      for (int k = 0; k < 13; k++) begin
         drive(tbl[k].r, tbl[k].v, tbl[k].rt, tbl[k].ct, tbl[k].d, tbl[k].rdy);
         #1;
         chk($sformatf("tbl%0d in_ready", k),   bus.in_ready,    64'(tbl[k].e_ready));
         chk($sformatf("tbl%0d row_enable", k), bus.row_enable,  64'(tbl[k].e_en));
         chk($sformatf("tbl%0d col_tag", k),    bus.col_tag_out, 64'(tbl[k].e_col));
         chk($sformatf("tbl%0d data", k),       bus.data_out,    tbl[k].e_data);
         chk($sformatf("tbl%0d drop", k),       drop_count,      64'(tbl[k].e_drop));
         settle();
         advance();
      end

      // Multicast to rows 2 and 7 with row 7 stalling for 3 cycles.
      row_id[2] = 4'd9; row_id[7] = 4'd9; row_id[9] = 4'd13;
      drive(1, 1, 4'h9, 4'h3, 64'h77, 12'hF7F); settle(); advance();
      drive(1, 0, 4'h0, 4'h0, 64'h0,  12'hF7F); settle(); advance();
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hF7F); settle();
         chk("mc_stall_en", bus.row_enable, 64'h0);
         advance();
      end
      drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle();
      chk("mc_en", bus.row_enable, 64'h084);
      chk("mc_data", bus.data_out, 64'h77);
      advance();
      drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle();
      chk("mc_after_en", bus.row_enable, 64'h0);
      advance();
      set_identity();

      // 300 unmatched packets saturate drop_count.
      acc = 0;
      for (int k = 0; k < 400 && acc < 300; k++) begin
         drive(1, 1, 4'hF, 4'h1, 64'(k), 12'hFFF); settle();
         if (bus.in_ready) acc++;
         advance();
      end
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle(); advance();
      end
      chk("drop_sat", drop_count, 64'd255);

      drive(0, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle(); advance();

      // Back-pressure: 5 accepted (4 FIFO + head), then 5 back-to-back enables in order.
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1, 1, 4'h1, 4'h6, 64'(100 + acc), 12'h000); settle();
         if (bus.in_ready) acc++;
         advance();
      end
      chk("full_accepts", acc, 5);
      drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle();
      chk("full_in_ready", bus.in_ready, 64'h0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle();
         end
         chk("drain_en", bus.row_enable, 64'h002);
         chk("drain_data", bus.data_out, 64'(100 + k));
         advance();
      end
      drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle();
      chk("drain_done_en", bus.row_enable, 64'h0);
      advance();

      // Reset mid-operation with head plus 3 buffered packets.
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1, acc < 4, 4'h1, 4'h4, 64'(200 + acc), 12'h000); settle();
         if (bus.in_ready && acc < 4) acc++;
         advance();
      end
      drive(0, 0, 4'h0, 4'h0, 64'h0, 12'h000); settle(); advance();
      for (int k = 0; k < 6; k++) begin
         drive(1, 0, 4'h0, 4'h0, 64'h0, 12'hFFF); settle();
         chk("rst_mid_en", bus.row_enable, 64'h0);
         chk("rst_mid_ready", bus.in_ready, 64'h1);
         advance();
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         if (k % 250 == 0) begin
            for (int i = 0; i < NR; i++) row_id[i] = 4'($urandom_range(0, 15));
         end
         rr = '0;
         for (int i = 0; i < NR; i++) rr[i] = ($urandom_range(0, 3) != 0);
         drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), {$urandom, $urandom}, rr);
         settle();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
